// File: rtl/sel_sequencer.sv
// Round-robin 6:1 mux-select sequencer with registered sel/grant and no bubble between grants.
// Define SEL_SEQ_TIMEOUT_EN to abandon a grant after 16 consecutive stalled HOLD cycles.
module sel_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic [5:0] req,
  input  logic       ready,
  output logic [2:0] sel,
  output logic       valid,
  output logic [5:0] grant,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] sel_nxt;
  logic [5:0] grant_nxt;
  logic [2:0] ptr_done;
  logic [2:0] win_idle;
  logic [2:0] win_done;

  // First set request at or after p, wrapping 5 -> 0; returns p when r is empty.
  function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [3:0] idx;
    w = p;
    for (int i = 5; i >= 0; i--) begin
      idx = {1'b0, p} + 4'(i);
      if (idx >= 4'd6) idx = idx - 4'd6;
      if (r[idx[2:0]]) w = idx[2:0];
    end
    return w;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  assign ptr_done = wrap_inc(sel);
  assign win_idle = rr_pick(req, ptr);
  assign win_done = rr_pick(req, ptr_done);
  assign valid    = (state == HOLD);

`ifdef SEL_SEQ_TIMEOUT_EN
  logic [3:0] cnt, cnt_nxt;
  logic       timeout_nxt;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      sel     <= 3'd0;
      grant   <= 6'd0;
`ifdef SEL_SEQ_TIMEOUT_EN
      cnt     <= 4'd0;
      timeout <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sel     <= sel_nxt;
      grant   <= grant_nxt;
`ifdef SEL_SEQ_TIMEOUT_EN
      cnt     <= cnt_nxt;
      timeout <= timeout_nxt;
`endif
    end
  end

`ifndef SEL_SEQ_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
`ifdef SEL_SEQ_TIMEOUT_EN
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = HOLD;
          sel_nxt   = win_idle;
`ifdef SEL_SEQ_TIMEOUT_EN
          cnt_nxt   = 4'd0;
`endif
        end else begin
          sel_nxt = 3'd0;
        end
      end
      HOLD: begin
        if (ready) begin
          // Completion re-arbitrates from the advanced pointer in the same edge.
          ptr_nxt = ptr_done;
`ifdef SEL_SEQ_TIMEOUT_EN
          cnt_nxt = 4'd0;
`endif
          if (|req) begin
            sel_nxt = win_done;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = 3'd0;
          end
        end else begin
`ifdef SEL_SEQ_TIMEOUT_EN
          if (cnt == 4'd15) begin
            state_nxt   = IDLE;
            ptr_nxt     = ptr_done;
            sel_nxt     = 3'd0;
            cnt_nxt     = 4'd0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 3'd0;
      end
    endcase
    grant_nxt = (state_nxt == HOLD) ? (6'd1 << sel_nxt) : 6'd0;
  end

endmodule

// File: tb/tb_sel_sequencer.sv
// Bench for sel_sequencer: directed scenarios plus randomized traffic against a queue-free
// behavioural arbiter model; honours SEL_SEQ_TIMEOUT_EN when defined.
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] req;
  logic       ready;
  logic [2:0] sel;
  logic       valid;
  logic [5:0] grant;
  logic       timeout;

  int vecs = 0;
  int miss = 0;

`ifdef SEL_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  sel_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .req    (req),
    .ready  (ready),
    .sel    (sel),
    .valid  (valid),
    .grant  (grant),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who currently owns the mux, who is first in line, how long it stalled.
  bit m_valid;
  bit m_to;
  int m_sel;
  int m_ptr;
  int m_stall;

  function automatic int pick(input logic [5:0] r, input int p);
    for (int k = 0; k < 6; k++)
      if (r[(p + k) % 6]) return (p + k) % 6;
    return 0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_to = 1'b0; m_sel = 0; m_ptr = 0; m_stall = 0;
  endtask

  task automatic model_step(input logic [5:0] r, input logic rd);
    m_to = 1'b0;
    if (!resetn) begin
      model_reset();
    end else if (!m_valid) begin
      if (r != 6'd0) begin
        m_sel = pick(r, m_ptr); m_valid = 1'b1; m_stall = 0;
      end else begin
        m_sel = 0;
      end
    end else if (rd) begin
      m_ptr = (m_sel + 1) % 6;
      m_stall = 0;
      if (r != 6'd0) m_sel = pick(r, m_ptr);
      else begin m_valid = 1'b0; m_sel = 0; end
    end else if (TO_EN && m_stall == 15) begin
      m_ptr = (m_sel + 1) % 6;
      m_valid = 1'b0; m_sel = 0; m_stall = 0; m_to = 1'b1;
    end else begin
      m_stall++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".sel"},     32'(sel),     32'(m_sel));
    chk({tag, ".valid"},   32'(valid),   32'(m_valid));
    chk({tag, ".grant"},   32'(grant),   m_valid ? (32'd1 << m_sel) : 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  task automatic cycle(input string tag, input logic [5:0] r, input logic rd);
    @(negedge clk);
    req = r; ready = rd;
    @(posedge clk);
    model_step(r, rd);
    #1 check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; req = 6'd0; ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  int nvalid;
  int nto;
  logic [5:0] rr;
  logic       rd;

  initial begin
    resetn = 1'b0; req = 6'd0; ready = 1'b0;
    model_reset();

    // Reset held for 3 cycles, then released with req idle
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst.sel", 32'(sel), 32'd0);
      chk("rst.valid", 32'(valid), 32'd0);
      chk("rst.grant", 32'(grant), 32'd0);
      chk("rst.timeout", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) cycle("idle", 6'd0, 1'b1);

    // Single request on channel 3
    cycle("single", 6'b001000, 1'b0);
    chk("single.sel3", 32'(sel), 32'd3);
    chk("single.grant", 32'(grant), 32'h08);
    cycle("single_done", 6'd0, 1'b1);
    chk("single.idle", 32'(valid), 32'd0);
    cycle("single_idle", 6'd0, 1'b0);

    // Back-to-back round robin from ptr=0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle("rr", 6'h3F, 1'b1);
      chk("rr.seq", 32'(sel), 32'(i % 6));
      chk("rr.valid", 32'(valid), 32'd1);
    end

    // Asynchronous reset mid-HOLD drops valid/grant before the next edge
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst.valid", 32'(valid), 32'd0);
    chk("arst.grant", 32'(grant), 32'd0);
    chk("arst.sel", 32'(sel), 32'd0);
    chk("arst.timeout", 32'(timeout), 32'd0);
    model_reset();
    req = 6'd0; ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cycle("arst_restart", 6'h3F, 1'b0);
    chk("arst.restart_ptr0", 32'(sel), 32'd0);

    // Wrap and skip after completing channel 4
    do_reset();
    cycle("wrap", 6'b010000, 1'b0);
    chk("wrap.sel4", 32'(sel), 32'd4);
    cycle("wrap", 6'b100001, 1'b1);
    chk("wrap.sel5", 32'(sel), 32'd5);
    cycle("wrap", 6'b100001, 1'b1);
    chk("wrap.sel0", 32'(sel), 32'd0);
    cycle("wrap", 6'b100001, 1'b0);
    chk("wrap.hold0", 32'(sel), 32'd0);
    cycle("wrap", 6'b100001, 1'b1);
    chk("wrap.sel5b", 32'(sel), 32'd5);
    cycle("wrap", 6'd0, 1'b1);

    // Stall for 20 cycles on channel 2
    do_reset();
    nvalid = 0; nto = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("stall", 6'b000100, 1'b0);
      if (valid === 1'b1) nvalid++;
      if (timeout === 1'b1) nto++;
      if (i < 16) chk("stall.valid_early", 32'(valid), 32'd1);
    end
    chk("stall.nvalid", 32'(nvalid), TO_EN ? 32'd19 : 32'd20);
    chk("stall.nto", 32'(nto), TO_EN ? 32'd1 : 32'd0);
    chk("stall.regrant", 32'(sel), 32'd2);

    // Ready arriving with the 16th stall cycle completes normally
    do_reset();
    cycle("coin", 6'b000100, 1'b0);
    repeat (15) cycle("coin", 6'b000100, 1'b0);
    cycle("coin", 6'b000100, 1'b1);
    chk("coin.timeout", 32'(timeout), 32'd0);
    chk("coin.valid", 32'(valid), 32'd1);
    cycle("coin", 6'd0, 1'b1);

    // Randomized traffic: balanced ready, then long stalls
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom % 4 == 0) ? 6'd0 : 6'($urandom);
      if (i < 200) rd = 1'($urandom % 2);
      else         rd = ($urandom % 12 == 0);
      cycle("rand", rr, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
